// File: rtl/switch_debouncer_pkg.sv
// Shared constants and helpers for the slide-switch conditioning stage.
// Imported by the per-bit debouncer and by the top level.
package switch_pkg;

  localparam int SW_WIDTH         = 4;
  localparam int DEBOUNCE_DEFAULT = 50000;

  // Counter width: clog2 of the debounce length, never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One switch bit: two-flop synchroniser, persistence counter, clean level,
// registered edge pulses and a sticky change flag.
module switch_debounce_bit
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = cnt_width(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  input  logic clear_changed,
  output logic sw_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] count;
  logic             accept;

  // A new level is accepted once it has disagreed with sw_clean for the
  // full debounce length; any agreement in between restarts the count.
  assign accept = (s2 != sw_clean) && (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      count      <= '0;
      sw_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      changed    <= 1'b0;
    end else begin
      s1         <= sw_raw;
      s2         <= s1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;

      if (s2 == sw_clean) begin
        count <= '0;
      end else if (!accept) begin
        count <= count + CNT_W'(1);
      end else begin
        count      <= '0;
        sw_clean   <= s2;
        rise_pulse <= s2;
        fall_pulse <= ~s2;
      end

      // A transition in the same cycle as a clear wins, so no event is lost.
      if (accept) begin
        changed <= 1'b1;
      end else if (clear_changed) begin
        changed <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH asynchronous slide-switch pins into clean levels for the
// PIO in_port, with per-bit rise/fall pulses and sticky change flags.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int WIDTH           = SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] changed,
  input  logic [WIDTH-1:0] clear_changed
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk           (clk),
      .reset         (reset),
      .sw_raw        (sw_raw[i]),
      .clear_changed (clear_changed[i]),
      .sw_clean      (sw_clean[i]),
      .rise_pulse    (rise_pulse[i]),
      .fall_pulse    (fall_pulse[i]),
      .changed       (changed[i])
    );
  end

endmodule
